// File: rtl/fifo36_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : fifo36_ctrl_pkg                                         |
// | Description: Shared types and defaults for the FIFO36 reset          |
// |              sequencer / write-port arbiter.                         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
package fifo36_ctrl_pkg;

  // Sequencer states: FIFO reset asserted, post-reset quiet time, normal use.
  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int DEF_RST_CYCLES    = 5;
  localparam int DEF_SETTLE_CYCLES = 3;

  // Used to size the shared down-counter for whichever phase is longer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo36_ctrl_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : rr_arbiter                                              |
// | Description: Combinational round-robin pick. Returns the first      |
// |              valid requester at or above ptr, wrapping modulo N.     |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]          valid,
  input  logic [$clog2(N)-1:0]  ptr,
  output logic [N-1:0]          grant,
  output logic [$clog2(N)-1:0]  idx
);

  localparam int            IW  = $clog2(N);
  localparam logic [IW:0]   C_N = (IW+1)'(N);

  // Walk candidates ptr, ptr+1, ... with wrap; the first valid one wins.
  // One spare bit on the candidate keeps ptr+k from overflowing before wrap.
  always_comb begin
    logic [IW:0] cand;
    logic        found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= C_N) begin
        cand = cand - C_N;
      end
      if (!found && valid[cand[IW-1:0]]) begin
        found                = 1'b1;
        grant[cand[IW-1:0]]  = 1'b1;
        idx                  = cand[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo36_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : fifo36_ctrl                                             |
// | Description: FIFO36E1 reset sequencer plus round-robin arbiter that  |
// |              shares the single write port between N_REQ requesters.  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module fifo36_ctrl
  import fifo36_ctrl_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DATA_WIDTH    = 72,
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_bits,
  output logic [N_REQ-1:0]            req_ready,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  input  logic                        deq_rden_in,
  output logic                        fifo_rst,
  output logic                        fifo_wren,
  output logic [DATA_WIDTH-1:0]       fifo_din,
  output logic                        fifo_rden,
  input  logic                        fifo_full,
  output logic                        ctrl_ready
);

  localparam int IW    = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max_int(RST_CYCLES, SETTLE_CYCLES) + 1);

  localparam logic [CNT_W-1:0] C_RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]    C_LAST        = IW'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]      ptr_q, ptr_d;

  logic               in_run;
  logic               arb_en;
  logic [N_REQ-1:0]   arb_valid;
  logic [N_REQ-1:0]   arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               any_grant;

  // Requests are masked before the arbiter so a blocked cycle yields no grant
  // at all; full and flush act combinationally with no registered path.
  assign in_run    = (state_q == ST_RUN);
  assign arb_en    = in_run & ~fifo_full & ~flush;
  assign arb_valid = req_valid & {N_REQ{arb_en}};
  assign any_grant = |arb_grant;

  rr_arbiter #(
    .N (N_REQ)
  ) u_arb (
    .valid (arb_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Sequencer state, phase counter and round-robin pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= C_RST_LOAD;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next state: count down HOLD then SETTLE; flush restarts from HOLD anywhere.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_SETTLE;
          cnt_d   = C_SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = C_RST_LOAD;
      end
    endcase
    if (flush) begin
      state_d = ST_HOLD;
      cnt_d   = C_RST_LOAD;
    end
  end

  // Outputs and pointer update; the granted word goes out in the handshake cycle.
  always_comb begin
    fifo_rst   = (state_q == ST_HOLD);
    ctrl_ready = in_run;
    fifo_rden  = in_run & deq_rden_in;
    req_ready  = arb_grant;
    fifo_wren  = any_grant;
    grant_id   = any_grant ? arb_idx : '0;
    fifo_din   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        fifo_din = req_bits[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    ptr_d = ptr_q;
    if (any_grant) begin
      ptr_d = (arb_idx == C_LAST) ? '0 : arb_idx + IW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo36_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_fifo36_ctrl                                          |
// | Description: Self-checking bench for fifo36_ctrl against a cycle     |
// |              model tracking time since the last reset/flush.         |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_fifo36_ctrl;

  localparam int N    = 4;
  localparam int DW   = 72;
  localparam int RSTC = 5;
  localparam int SETC = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_bits = '0;
  logic [N-1:0]      req_ready;
  logic [1:0]        grant_id;
  logic              deq_rden_in = 1'b0;
  logic              fifo_rst;
  logic              fifo_wren;
  logic [DW-1:0]     fifo_din;
  logic              fifo_rden;
  logic              fifo_full = 1'b0;
  logic              ctrl_ready;

  always #5 clk = ~clk;

  fifo36_ctrl #(
    .N_REQ         (N),
    .DATA_WIDTH    (DW),
    .RST_CYCLES    (RSTC),
    .SETTLE_CYCLES (SETC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_bits    (req_bits),
    .req_ready   (req_ready),
    .grant_id    (grant_id),
    .deq_rden_in (deq_rden_in),
    .fifo_rst    (fifo_rst),
    .fifo_wren   (fifo_wren),
    .fifo_din    (fifo_din),
    .fifo_rden   (fifo_rden),
    .fifo_full   (fifo_full),
    .ctrl_ready  (ctrl_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: cycles elapsed since reset release or last flush,
  // next-priority requester, and the expected grant for the current cycle.
  int          since = 0;
  int          mptr  = 0;
  int          e_g   = -1;
  logic [DW-1:0] data [N];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = {$urandom, $urandom, $urandom};
    return w;
  endfunction

  task automatic compare();
    logic         run_m;
    logic [N-1:0] oh;
    run_m = (since >= RSTC + SETC);
    e_g   = -1;
    if (run_m && !fifo_full && !flush) begin
      for (int k = 0; k < N; k++) begin
        if (e_g < 0 && req_valid[(mptr + k) % N]) e_g = (mptr + k) % N;
      end
    end
    oh = '0;
    if (e_g >= 0) oh[e_g] = 1'b1;
    check("fifo_rst",   fifo_rst,   since < RSTC);
    check("ctrl_ready", ctrl_ready, run_m);
    check("fifo_rden",  fifo_rden,  run_m && deq_rden_in);
    check("req_ready",  req_ready,  oh);
    check("fifo_wren",  fifo_wren,  e_g >= 0);
    check("grant_id",   grant_id,   (e_g >= 0) ? e_g : 0);
    check("fifo_din",   fifo_din,   (e_g >= 0) ? data[e_g] : '0);
  endtask

  task automatic update();
    if (reset) begin
      since = 0;
      mptr  = 0;
    end else begin
      if (e_g >= 0) begin
        mptr      = (e_g + 1) % N;
        data[e_g] = rand_word();
      end
      if (flush) since = 0;
      else if (since < 100000) since++;
    end
  endtask

  // One clock: drive at the falling edge, check mid-cycle, advance model at the rising edge.
  task automatic cyc(input logic [N-1:0] v, input logic fl, input logic fu,
                     input logic rd, input logic r);
    @(negedge clk);
    reset       = r;
    req_valid   = v;
    flush       = fl;
    fifo_full   = fu;
    deq_rden_in = rd;
    for (int i = 0; i < N; i++) req_bits[i*DW +: DW] = data[i];
    #1;
    compare();
    @(posedge clk);
    update();
  endtask

  logic [N-1:0] pend;
  logic [N-1:0] rv;

  initial begin
    for (int i = 0; i < N; i++) data[i] = rand_word();

    // Held in reset, then released with every requester asking.
    cyc(4'b1111, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(4'b1111, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 18; c++) cyc(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);

    // Steer the pointer to 2, then two requesters below it.
    cyc(4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) cyc(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);

    // FIFO full for three cycles, then released.
    for (int c = 0; c < 3; c++) cyc(4'b0100, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);

    // Double flush two cycles apart; reads requested throughout.
    cyc(4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 12; c++) cyc(4'b1111, 1'b0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset asserted mid-cycle during a transfer.
    @(negedge clk);
    req_valid = 4'b1010; flush = 1'b0; fifo_full = 1'b0; deq_rden_in = 1'b1;
    for (int i = 0; i < N; i++) req_bits[i*DW +: DW] = data[i];
    #1;
    compare();
    #2;
    reset = 1'b1;
    #1;
    check("arst_fifo_rst",   fifo_rst,   1'b1);
    check("arst_fifo_wren",  fifo_wren,  1'b0);
    check("arst_req_ready",  req_ready,  '0);
    check("arst_fifo_din",   fifo_din,   '0);
    check("arst_fifo_rden",  fifo_rden,  1'b0);
    check("arst_ctrl_ready", ctrl_ready, 1'b0);
    since = 0;
    mptr  = 0;
    @(posedge clk);
    update();
    cyc(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 12; c++) cyc(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random traffic; a requester keeps valid and data until granted.
    pend = '0;
    for (int c = 0; c < 800; c++) begin
      rv = N'($urandom & $urandom);
      cyc(pend | rv,
          ($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 20),
          1'($urandom),
          1'b0);
      pend = req_valid;
      if (e_g >= 0) pend[e_g] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
